// File: rtl/blink_pkg.sv
// ---------------------------------------------------------------------------
// blink_pkg
// Shared definitions for the blink meter and the blink generator.
//   blink_state_t : segment-tracking FSM states (IDLE / HIGH / LOW)
//   ticks_per_ms  : clock cycles per millisecond, never less than 1
//   ms_to_ticks   : converts a millisecond count into clock cycles
// ---------------------------------------------------------------------------
package blink_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } blink_state_t;

  // Clocks slower than 1 kHz still get one tick per millisecond so the
  // prescaler never degenerates to a zero-length count.
  function automatic int ticks_per_ms(input int f_clk_hz);
    return ((f_clk_hz / 1000) < 1) ? 1 : (f_clk_hz / 1000);
  endfunction

  function automatic int ms_to_ticks(input int f_clk_hz, input int ms);
    return ticks_per_ms(f_clk_hz) * ms;
  endfunction

endpackage

// File: rtl/blink_meter_sig_sync.sv
// ---------------------------------------------------------------------------
// sig_sync
// Brings the asynchronous blink input into the clk domain and flags edges.
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low clear of all three flops
//   sig_in : raw pin, asynchronous to clk
//   s      : synchronized level (second synchronizer flop)
//   rise   : s is 1 and was 0 on the previous cycle
//   fall   : s is 0 and was 1 on the previous cycle
// A pin change reaches rise/fall after two clocks and is acted on by the
// consumer at the third clock edge.
// ---------------------------------------------------------------------------
module sig_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic s,
  output logic rise,
  output logic fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= sig_in;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign s    = r_sync;
  assign rise = r_sync & ~r_prev;
  assign fall = ~r_sync & r_prev;

endmodule

// File: rtl/blink_meter.sv
// ---------------------------------------------------------------------------
// blink_meter
// Measures the high and low segment lengths of a slow blink waveform in
// milliseconds and flags an input that has stopped toggling.
//   clk         : system clock, rising edge
//   rst_n       : asynchronous active-low reset (release synchronized outside)
//   sig_in      : blink waveform, asynchronous to clk
//   on_ms       : last complete high-segment length, ms
//   off_ms      : last complete low-segment length, ms
//   period_ms   : on_ms + off_ms, one bit wider so it never saturates
//   meas_valid  : one-cycle pulse when a new on/off pair is published
//   stuck       : current segment has lasted at least TIMEOUT_MS
//   stuck_level : synchronized level while stuck, 0 otherwise
//   dbg_state   : current FSM state (blink_state_t encoding)
//
// Handshake: meas_valid is a pure strobe with no ready; on_ms, off_ms and
// period_ms change only in the cycle meas_valid is high and hold otherwise,
// so a consumer may sample them on the strobe or any time afterwards.
//
// A segment of N cycles (edge detection to edge detection) reports
// floor(N / TICKS_PER_MS) ms. The counters restart on the detection cycle,
// so the value latched at the next edge is the counter value including the
// detection cycle itself (w_ms_next).
// ---------------------------------------------------------------------------
module blink_meter
  import blink_pkg::*;
#(
  parameter int F_CLK_HZ   = 25_000_000,
  parameter int MS_W       = 16,
  parameter int TIMEOUT_MS = 2000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sig_in,
  output logic [MS_W-1:0] on_ms,
  output logic [MS_W-1:0] off_ms,
  output logic [MS_W:0]   period_ms,
  output logic            meas_valid,
  output logic            stuck,
  output logic            stuck_level,
  output logic [1:0]      dbg_state
);

  localparam int TICKS_PER_MS = ticks_per_ms(F_CLK_HZ);
  localparam int PRE_W        = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_MS - 1);
  localparam logic [MS_W-1:0]  MS_MAX   = '1;

  // A timeout beyond the saturated counter range can never be reached;
  // the comparison is then constant-false rather than truncated.
  localparam int  MS_MAX_INT        = (2 ** MS_W) - 1;
  localparam bit  TIMEOUT_REACHABLE = (TIMEOUT_MS <= MS_MAX_INT);
  localparam logic [MS_W-1:0] TIMEOUT_VAL =
    TIMEOUT_REACHABLE ? MS_W'(TIMEOUT_MS) : MS_MAX;

  // Synchronizer / edge detector
  logic w_s;
  logic w_rise;
  logic w_fall;
  logic w_edge;

  sig_sync u_sig_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_in (sig_in),
    .s      (w_s),
    .rise   (w_rise),
    .fall   (w_fall)
  );

  assign w_edge = w_rise | w_fall;

  // Segment timing: prescaler wraps every TICKS_PER_MS cycles and bumps the
  // ms counter, which sticks at its maximum instead of wrapping.
  logic [PRE_W-1:0] r_pre;
  logic [MS_W-1:0]  r_ms;
  logic             w_tick;
  logic [PRE_W-1:0] w_pre_next;
  logic [MS_W-1:0]  w_ms_next;
  logic             w_timeout;

  assign w_tick     = (r_pre == PRE_LAST);
  assign w_pre_next = w_tick ? '0 : (r_pre + PRE_W'(1));
  assign w_ms_next  = (w_tick && (r_ms != MS_MAX)) ? (r_ms + MS_W'(1)) : r_ms;
  assign w_timeout  = TIMEOUT_REACHABLE && (w_ms_next >= TIMEOUT_VAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
      r_ms  <= '0;
    end else if (w_edge) begin
      r_pre <= '0;
      r_ms  <= '0;
    end else begin
      r_pre <= w_pre_next;
      r_ms  <= w_ms_next;
    end
  end

  // Segment FSM with registered results
  blink_state_t    r_state;
  logic [MS_W-1:0] r_pend_on;
  logic [MS_W-1:0] r_on;
  logic [MS_W-1:0] r_off;
  logic [MS_W:0]   r_period;
  logic            r_meas_valid;
  logic            r_stuck;
  logic            r_stuck_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_pend_on     <= '0;
      r_on          <= '0;
      r_off         <= '0;
      r_period      <= '0;
      r_meas_valid  <= 1'b0;
      r_stuck       <= 1'b0;
      r_stuck_level <= 1'b0;
    end else begin
      r_meas_valid <= 1'b0;
      if (w_edge) begin
        // An edge always ends a stuck condition; the FSM is already in IDLE
        // then, so the edge is handled as an IDLE edge below. An edge also
        // wins over a timeout landing on the same cycle.
        r_stuck       <= 1'b0;
        r_stuck_level <= 1'b0;
        case (r_state)
          ST_IDLE: begin
            // Falling edges here only end a partial segment; discard it.
            if (w_rise) begin
              r_state <= ST_HIGH;
            end
          end
          ST_HIGH: begin
            if (w_fall) begin
              r_pend_on <= w_ms_next;
              r_state   <= ST_LOW;
            end
          end
          ST_LOW: begin
            if (w_rise) begin
              r_on         <= r_pend_on;
              r_off        <= w_ms_next;
              r_period     <= {1'b0, r_pend_on} + {1'b0, w_ms_next};
              r_meas_valid <= 1'b1;
              r_state      <= ST_HIGH;
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end else if (w_timeout) begin
        // Input stopped toggling: abandon the period in progress but keep
        // the last published measurement.
        r_stuck       <= 1'b1;
        r_stuck_level <= w_s;
        r_state       <= ST_IDLE;
      end
    end
  end

  assign on_ms       = r_on;
  assign off_ms      = r_off;
  assign period_ms   = r_period;
  assign meas_valid  = r_meas_valid;
  assign stuck       = r_stuck;
  assign stuck_level = r_stuck_level;
  assign dbg_state   = r_state;

endmodule
